// File: rtl/keypad_pkg.sv
// keypad_pkg: declarations shared by the keypad scanner and its debouncer
// (and reused by the game controller's tests).
//   KEY_NOKEY / KEY_RESET : special key codes (no key, game-reset key '#')
//   scan_kind_e           : classification of one completed four-column scan
//   scan_result_t         : scan classification plus the single key's code
//   key_code()            : row/col position -> key code ('*' reads as no key)
package keypad_pkg;

    localparam logic [3:0] KEY_NOKEY = 4'hE;
    localparam logic [3:0] KEY_RESET = 4'hF;

    typedef enum logic [1:0] {
        SCAN_NONE  = 2'd0,
        SCAN_MULTI = 2'd1,
        SCAN_CODE  = 2'd2
    } scan_kind_e;

    typedef struct packed {
        scan_kind_e kind;
        logic [3:0] code;
    } scan_result_t;

    // Keypad layout, rows top to bottom:  1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = KEY_NOKEY;   // '*' is unmapped
            4'hD:    code = 4'h0;
            4'hE:    code = KEY_RESET;   // '#'
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: whole-scan debouncer for the keypad scanner.
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   scan_vld_i   : one-cycle pulse, a full scan result is present
//   scan_multi_i : the scan saw two or more keys (ghosting, ignored)
//   scan_code_i  : single-key code of the scan, KEY_NOKEY for no key
//   key_o        : reported (debounced) key code
//   strobe_o     : one-cycle pulse when key_o changes to a real key
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_vld_i,
    input  logic       scan_multi_i,
    input  logic [3:0] scan_code_i,
    output logic [3:0] key_o,
    output logic       strobe_o
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

    // The candidate uses KEY_NOKEY to mean "no key", so a NONE candidate
    // reports as NOKEY without any translation.
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rep_q, rep_d;
    logic       strobe_q, strobe_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q   <= KEY_NOKEY;
            cnt_q    <= 4'd0;
            rep_q    <= KEY_NOKEY;
            strobe_q <= 1'b0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            strobe_q <= strobe_d;
        end
    end

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        strobe_d = 1'b0;
        if (scan_vld_i) begin
            if (scan_multi_i) begin
                // Ghosted scan: restart the match run but keep everything else.
                cnt_d = 4'd0;
            end else begin
                if (scan_code_i != cand_q) begin
                    cand_d = scan_code_i;
                    cnt_d  = 4'd1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 4'd1;
                end
                if ((cnt_d == CNT_MAX) && (cand_d != rep_q)) begin
                    rep_d    = cand_d;
                    strobe_d = (cand_d != KEY_NOKEY);
                end
            end
        end
    end

    assign key_o    = rep_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 membrane keypad scanner with whole-scan debounce.
//   clk        : system clock
//   reset      : asynchronous active-low reset
//   row        : keypad rows, active-low, asynchronous to clk
//   col        : keypad columns, active-low, exactly one low at a time
//   keyPress   : debounced key code, KEY_NOKEY when no key
//   key_strobe : one-cycle pulse on each new valid key
// Each column is driven for SCAN_DIV cycles; the synchronized rows are
// sampled on the last cycle of a column, and after column 3 the whole scan
// is classified and handed to the debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] keyPress,
    output logic       key_strobe
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [3:0]       col_q;
    logic [1:0]       acc_cnt_q, acc_cnt_d;   // keys seen so far, saturates at 2
    logic [3:0]       acc_code_q, acc_code_d; // code of the first key seen

    logic             sample;
    logic             scan_done;
    logic [3:0]       pressed;
    logic [2:0]       col_hits;
    logic [2:0]       total;
    logic [3:0]       col_code;
    scan_result_t     scan_res;

    assign sample    = (div_q == DIV_LAST);
    assign scan_done = sample && (col_idx_q == 2'd3);
    assign pressed   = ~row_sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= KEY_NOKEY;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
            if (sample) begin
                div_q     <= '0;
                col_idx_q <= col_idx_q + 2'd1;
                col_q     <= {col_q[2:0], col_q[3]};
                if (scan_done) begin
                    acc_cnt_q  <= 2'd0;
                    acc_code_q <= KEY_NOKEY;
                end else begin
                    acc_cnt_q  <= acc_cnt_d;
                    acc_code_q <= acc_code_d;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

    // Code of the lowest asserted row in the current column; it only matters
    // when it turns out to be the single key of the scan.
    always_comb begin
        col_code = KEY_NOKEY;
        if (pressed[3]) col_code = key_code(2'd3, col_idx_q);
        if (pressed[2]) col_code = key_code(2'd2, col_idx_q);
        if (pressed[1]) col_code = key_code(2'd1, col_idx_q);
        if (pressed[0]) col_code = key_code(2'd0, col_idx_q);
    end

    always_comb begin
        col_hits   = {2'b00, pressed[0]} + {2'b00, pressed[1]}
                   + {2'b00, pressed[2]} + {2'b00, pressed[3]};
        total      = {1'b0, acc_cnt_q} + col_hits;
        acc_cnt_d  = (total >= 3'd2) ? 2'd2 : total[1:0];
        acc_code_d = (acc_cnt_q == 2'd0) ? col_code : acc_code_q;

        scan_res.kind = SCAN_NONE;
        scan_res.code = KEY_NOKEY;
        if (acc_cnt_d == 2'd2) begin
            scan_res.kind = SCAN_MULTI;
        end else if ((acc_cnt_d == 2'd1) && (acc_code_d != KEY_NOKEY)) begin
            scan_res.kind = SCAN_CODE;
            scan_res.code = acc_code_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .scan_vld_i   (scan_done),
        .scan_multi_i (scan_res.kind == SCAN_MULTI),
        .scan_code_i  (scan_res.code),
        .key_o        (keyPress),
        .strobe_o     (key_strobe)
    );

    assign col = col_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 membrane keypad and produces the debounced 4-bit key code that feeds the game controller's `keyPress` input. Drives one column low at a time, samples the active-low rows through a synchronizer, and debounces whole-scan results. Holds the code steady while the key is held and emits a one-cycle strobe on each new press. Sits between the board keypad pins and the game-control FSM.

## Interface
- `SCAN_DIV`, 50000: clock cycles each column is driven; must be ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full-scan results needed to change the reported key; range 1..15.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset. Single clock domain.
- `row`  in  4  keypad rows, active-low, externally pulled up; asynchronous to `clk`.
- `col`  out  4  keypad columns, active-low; exactly one bit low at any time.
- `keyPress`  out  4  debounced key code; `4'hE` (NOKEY) when no key.
- `key_strobe`  out  1  one-cycle pulse when `keyPress` changes to a valid key code.

## Operation
- Key map, row r / col c, 0-indexed:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: * 0 # D
- Codes: digits 0-9 → 0..9; A..D → 10..13; `#` → 15 (game reset key); `*` is unmapped and reads as no key. NOKEY = 14.
- `row` passes through a 2-flop synchronizer before any use.
- Column counter: 0→1→2→3→0. `col` = ~(1<<c). A divider counts 0..SCAN_DIV-1 per column.
- Sample the synchronized rows on the last divider cycle of each column. This allows settling time of SCAN_DIV-1 cycles, which covers the 2-cycle synchronizer.
- Per-scan accumulator after column 3:
  - zero asserted keys → NONE
  - exactly one asserted key → its code (`*` → NONE)
  - two or more → MULTI
- Debounce FSM, applied once per completed scan:
  - MULTI: clear the match counter; candidate unchanged; reported key unchanged (ghosting rejection).
  - result ≠ candidate: candidate ← result; counter ← 1.
  - result = candidate: counter saturates at DEBOUNCE_SCANS.
  - When counter reaches DEBOUNCE_SCANS and candidate ≠ reported value: reported ← candidate (NONE maps to NOKEY).
- `key_strobe` pulses only when the reported value changes to a non-NOKEY code.
  - Direct key-to-key change (e.g. 5 → 6 with no release seen): one strobe.
  - Release (change to NOKEY): no strobe.
- A held key keeps `keyPress` constant indefinitely, so the game controller's slow sampler always sees it.

## Timing
- Reset values:
  - `col` = `4'b1110`
  - `keyPress` = `4'hE`
  - `key_strobe` = 0
  - divider, column, accumulator, candidate and counter all cleared; candidate = NONE
- Reset mid-scan aborts the scan. Scanning restarts at column 0 on the first clock after deassertion.
- Scan period = 4·SCAN_DIV cycles.
- Press-to-report latency: between (DEBOUNCE_SCANS-1)·4·SCAN_DIV+1 and (DEBOUNCE_SCANS+1)·4·SCAN_DIV+2 cycles after rows settle.
- `keyPress` and `key_strobe` update in the same cycle, one cycle after the column-3 sample.
- All outputs are registered. No combinational path from `row` to any output.

## Structure
- Shared package `keypad_pkg` holds:
  - constants KEY_NOKEY=4'hE, KEY_RESET=4'hF
  - scan-result encoding: NONE, MULTI, CODE
  - the row/col→code map function, shared with the game controller's tests
- One sub-module, `keypad_debounce`: scan result in → candidate/counter/reported register and strobe out. The scanner top keeps the divider, column rotation, synchronizer and accumulator.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (scan = 16 cycles).
- Reset released, no key → `col` rotates 1110,1101,1011,0111 every 4 cycles; `keyPress`=E; no strobe over 10 scans.
- Hold row1/col1 ("5") steady → `keyPress`=5 with a single strobe within 34..66 cycles; unchanged for 20 further scans. Release → returns to E within 4 scans, no strobe.
- Hold "5" and toggle rows every 3 cycles for 2 scans (bounce), then hold → exactly one strobe, `keyPress`=5; no intermediate codes.
- Press "1" and "6" together → MULTI; `keyPress` stays at its prior value, no strobe. Release "6" → reports 1 after 3 scans.
- Press `#` → `keyPress`=F with strobe. Press `*` alone → remains E.
- Assert `reset` low mid-scan while "9" is reported → outputs go to reset values immediately (`col`=1110, E). After release with "9" still held → re-reported with a strobe after debounce.
